// File: rtl/data_cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache with RV32 load/store width decode.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module data_cache_controller #(
  parameter int unsigned SET_BITS = 3
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [3:0]     READ_EN,
  input  logic [2:0]     WRITE_EN,
  input  logic [31:0]    ADDR,
  input  logic [31:0]    WRITE_DATA,
  output logic [31:0]    READ_DATA,
  output logic           BUSY_WAIT,
  output logic           MEM_READ,
  output logic           MEM_WRITE,
  output logic [27:0]    MEM_ADDR,
  output logic [127:0]   MEM_WRITE_DATA,
  input  logic [127:0]   MEM_READ_DATA,
`ifdef DCACHE_STATS_EN
  output logic [31:0]    HIT_COUNT,
  output logic [31:0]    MISS_COUNT,
`endif
  input  logic           MEM_BUSY_WAIT
);

  localparam int unsigned Sets = 1 << SET_BITS;
  localparam int unsigned TagW = 28 - SET_BITS;

  typedef enum logic [1:0] {StIdle, StWriteback, StAllocate, StUpdate} state_t;

  state_t              state_q;
  logic [Sets-1:0]     valid_q;
  logic [Sets-1:0]     dirty_q;
  logic [TagW-1:0]     tag_q   [Sets];
  logic [127:0]        data_q  [Sets];
  logic [127:0]        fill_q;
  logic [31:0]         read_data_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic [27:0]         mem_addr_q;
  logic [127:0]        mem_wdata_q;
`ifdef DCACHE_STATS_EN
  logic                after_update_q;
  logic [31:0]         hit_count_q;
  logic [31:0]         miss_count_q;
`endif

  logic [SET_BITS-1:0] index;
  logic [TagW-1:0]     tag;
  logic [3:0]          offset;
  logic                rd_req;
  logic                wr_req;
  logic                req;
  logic                hit;
  logic [127:0]        blk;
  logic [127:0]        st_block;
  logic [31:0]         load_data;
  logic [7:0]          sel_byte;
  logic [15:0]         sel_half;
  logic [31:0]         sel_word;

  assign index  = ADDR[3+SET_BITS:4];
  assign tag    = ADDR[31:4+SET_BITS];
  assign offset = ADDR[3:0];
  assign rd_req = READ_EN[3];
  assign wr_req = WRITE_EN[2];
  assign req    = rd_req | wr_req;
  assign hit    = valid_q[index] && (tag_q[index] == tag);
  assign blk    = data_q[index];

  // Halfword and word selects drop the low address bits, so misaligned accesses round down.
  assign sel_byte = blk[{offset, 3'b000} +: 8];
  assign sel_half = blk[{offset[3:1], 4'b0000} +: 16];
  assign sel_word = blk[{offset[3:2], 5'b00000} +: 32];

  always_comb begin
    load_data = sel_word;
    case (READ_EN[2:0])
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_data = {24'h0, sel_byte};
      3'b101:  load_data = {16'h0, sel_half};
      default: load_data = sel_word;
    endcase
  end

  always_comb begin
    st_block = blk;
    case (WRITE_EN[1:0])
      2'b00:   st_block[{offset, 3'b000} +: 8] = WRITE_DATA[7:0];
      2'b01:   st_block[{offset[3:1], 4'b0000} +: 16] = WRITE_DATA[15:0];
      default: st_block[{offset[3:2], 5'b00000} +: 32] = WRITE_DATA;
    endcase
  end

  // READ_DATA is live on a load hit and otherwise shows the last load result.
  assign READ_DATA = RESET ? 32'h0 :
                     ((state_q == StIdle) && rd_req && hit) ? load_data : read_data_q;
  assign BUSY_WAIT = !RESET && (((state_q == StIdle) && req && !hit) || (state_q != StIdle));
  assign MEM_READ       = !RESET && mem_read_q;
  assign MEM_WRITE      = !RESET && mem_write_q;
  assign MEM_ADDR       = mem_addr_q;
  assign MEM_WRITE_DATA = mem_wdata_q;
`ifdef DCACHE_STATS_EN
  assign HIT_COUNT  = hit_count_q;
  assign MISS_COUNT = miss_count_q;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      dirty_q     <= '0;
      read_data_q <= 32'h0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 28'h0;
      mem_wdata_q <= 128'h0;
`ifdef DCACHE_STATS_EN
      after_update_q <= 1'b0;
      hit_count_q    <= 32'h0;
      miss_count_q   <= 32'h0;
`endif
    end else begin
`ifdef DCACHE_STATS_EN
      after_update_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (req && hit) begin
            if (rd_req) read_data_q <= load_data;
            if (wr_req) begin
              data_q[index]  <= st_block;
              dirty_q[index] <= 1'b1;
            end
`ifdef DCACHE_STATS_EN
            // The replayed request right after a fill is not a fresh hit.
            if (!after_update_q) hit_count_q <= hit_count_q + 32'd1;
`endif
          end else if (req) begin
`ifdef DCACHE_STATS_EN
            miss_count_q <= miss_count_q + 32'd1;
`endif
            if (valid_q[index] && dirty_q[index]) begin
              mem_write_q <= 1'b1;
              mem_addr_q  <= {tag_q[index], index};
              mem_wdata_q <= data_q[index];
              state_q     <= StWriteback;
            end else begin
              mem_read_q <= 1'b1;
              mem_addr_q <= ADDR[31:4];
              state_q    <= StAllocate;
            end
          end
        end
        StWriteback: begin
          if (!MEM_BUSY_WAIT) begin
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b1;
            mem_addr_q  <= ADDR[31:4];
            state_q     <= StAllocate;
          end
        end
        StAllocate: begin
          if (!MEM_BUSY_WAIT) begin
            mem_read_q <= 1'b0;
            fill_q     <= MEM_READ_DATA;
            state_q    <= StUpdate;
          end
        end
        StUpdate: begin
          data_q[index]  <= fill_q;
          tag_q[index]   <= tag;
          valid_q[index] <= 1'b1;
          dirty_q[index] <= 1'b0;
          state_q        <= StIdle;
`ifdef DCACHE_STATS_EN
          after_update_q <= 1'b1;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
